// File: rtl/counter_arb_pkg.sv
// Shared definitions for the counter arbiter slice.
//   state_t    : FSM encoding (IDLE, RUN)
//   DEF_WIDTH  : default counter/limit width
//   DEF_NREQ   : default number of requesters
package counter_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req     in  NREQ : request vector
//   ptr     in  IDXW : highest-priority index for this search
//   win_oh  out NREQ : one-hot winner (zero if no request)
//   win_idx out IDXW : winner index (zero if no request)
//   valid   out 1    : at least one request present
module rr_pick
  import counter_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IDXW-1:0] win_idx,
  output logic            valid
);

  int cand;

  // Walk the requesters starting at ptr, wrapping past NREQ-1; the first
  // set bit encountered wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    valid   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin owner of a shared up-counter.
// A granted requester gets the counter for limit+1 cycles (count 0..lim),
// then receives a one-cycle done pulse.
//   clk    in  1          : clock, rising edge
//   rst_n  in  1          : synchronous active-low reset
//   req    in  NREQ       : request levels (hold until done, drop to cancel)
//   limit  in  NREQ*WIDTH : per-requester terminal count, slice i at i*WIDTH
//   gnt    out NREQ       : registered one-hot grant
//   done   out NREQ       : registered one-hot completion pulse
//   busy   out 1          : high while a grant is active
//   count  out WIDTH      : registered shared counter value
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] limit,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_n;
  logic [IDXW-1:0]  ptr, ptr_n;
  logic [IDXW-1:0]  gidx, gidx_n;
  logic [WIDTH-1:0] lim, lim_n;
  logic [NREQ-1:0]  gnt_n, done_n;
  logic             busy_n;
  logic [WIDTH-1:0] count_n;
  logic [IDXW-1:0]  ptr_after;

  logic [NREQ-1:0]  pick_oh;
  logic [IDXW-1:0]  pick_idx;
  logic             pick_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .valid   (pick_valid)
  );

  // The requester just served drops to lowest priority.
  assign ptr_after = (gidx == IDXW'(NREQ - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_n = state;
    gnt_n   = '0;
    done_n  = '0;
    busy_n  = 1'b0;
    count_n = count;
    lim_n   = lim;
    ptr_n   = ptr;
    gidx_n  = gidx;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = RUN;
          gnt_n   = pick_oh;
          busy_n  = 1'b1;
          count_n = '0;
          gidx_n  = pick_idx;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) lim_n = limit[i*WIDTH +: WIDTH];
          end
        end
      end
      RUN: begin
        // gnt is one-hot, so masking req with it isolates the owner's level.
        if ((req & gnt) == '0) begin
          state_n = IDLE;
          ptr_n   = ptr_after;
        end else if (count == lim) begin
          state_n = IDLE;
          done_n  = gnt;
          ptr_n   = ptr_after;
        end else begin
          gnt_n   = gnt;
          busy_n  = 1'b1;
          count_n = count + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
      ptr   <= '0;
      gidx  <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      busy  <= busy_n;
      count <= count_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
    end
  end

  // The latched limit is only consulted while gnt is set, so it needs no reset.
  always_ff @(posedge clk) begin
    lim <= lim_n;
  end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter (NREQ=4, WIDTH=8).
module tb_counter_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] limit;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      count;

  int n_chk;
  int n_fail;

  counter_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .limit (limit),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle at the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_lim(input int idx, input int val);
    limit[idx*WIDTH +: WIDTH] = WIDTH'(val);
  endtask

  logic [3:0] fair_exp [6];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = 4'b1111;
    limit  = '0;
    @(negedge clk);

    // Reset held three cycles with all requests asserted
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_count", 32'(count), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    check("rel_gnt", 32'(gnt), 32'h1);
    check("rel_busy", 32'(busy), 32'h1);

    // Single request, limit 5
    do_reset();
    set_lim(2, 5);
    req = 4'b0100;
    for (int k = 0; k <= 5; k++) begin
      tick();
      check("single_gnt", 32'(gnt), 32'h4);
      check("single_count", 32'(count), 32'(k));
    end
    tick();
    check("single_done", 32'(done), 32'h4);
    check("single_done_gnt", 32'(gnt), 32'h0);
    check("single_done_busy", 32'(busy), 32'h0);
    check("single_hold", 32'(count), 32'h5);
    req = 4'b0000;
    tick();
    check("single_done_clr", 32'(done), 32'h0);
    check("single_idle_gnt", 32'(gnt), 32'h0);
    check("single_idle_count", 32'(count), 32'h5);

    // Fairness, requester 2 never asks
    do_reset();
    limit = '0;
    req = 4'b1011;
    fair_exp[0] = 4'b0001; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b1000;
    fair_exp[3] = 4'b0001; fair_exp[4] = 4'b0010; fair_exp[5] = 4'b1000;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fair_gnt", 32'(gnt), 32'(fair_exp[k]));
      check("fair_gnt_done", 32'(done), 32'h0);
      tick();
      check("fair_done", 32'(done), 32'(fair_exp[k]));
      check("fair_done_gnt", 32'(gnt), 32'h0);
    end
    req = 4'b0000;
    tick();

    // Cancel at count 3
    do_reset();
    set_lim(1, 10);
    req = 4'b0010;
    tick();
    check("cancel_gnt", 32'(gnt), 32'h2);
    for (int k = 1; k <= 3; k++) tick();
    check("cancel_count3", 32'(count), 32'h3);
    req = 4'b0000;
    tick();
    check("cancel_gnt_off", 32'(gnt), 32'h0);
    check("cancel_no_done", 32'(done), 32'h0);
    check("cancel_busy", 32'(busy), 32'h0);
    check("cancel_hold", 32'(count), 32'h3);
    set_lim(0, 2);
    req = 4'b0011;
    tick();
    check("cancel_next_gnt", 32'(gnt), 32'h1);
    check("cancel_next_done", 32'(done), 32'h0);
    check("cancel_next_count", 32'(count), 32'h0);
    req = 4'b0000;
    tick();

    // Full-range limit with a mid-run limit change that must be ignored
    do_reset();
    set_lim(0, 255);
    req = 4'b0001;
    for (int k = 0; k <= 255; k++) begin
      tick();
      check("max_count", 32'(count), 32'(k));
      if (k == 10) set_lim(0, 3);
    end
    check("max_gnt_end", 32'(gnt), 32'h1);
    tick();
    check("max_done", 32'(done), 32'h1);
    check("max_hold", 32'(count), 32'hff);
    req = 4'b0000;
    tick();
    check("max_after_gnt", 32'(gnt), 32'h0);
    check("max_after_count", 32'(count), 32'hff);

    // Zero limit: one grant cycle, then done
    do_reset();
    set_lim(3, 0);
    req = 4'b1000;
    tick();
    check("zero_gnt", 32'(gnt), 32'h8);
    check("zero_count", 32'(count), 32'h0);
    tick();
    check("zero_done", 32'(done), 32'h8);
    check("zero_done_gnt", 32'(gnt), 32'h0);
    req = 4'b0000;
    tick();
    check("zero_done_clr", 32'(done), 32'h0);

    // Reset during a run
    do_reset();
    set_lim(2, 20);
    req = 4'b0100;
    for (int k = 0; k <= 4; k++) tick();
    check("mrst_count4", 32'(count), 32'h4);
    rst_n = 1'b0;
    tick();
    check("mrst_gnt", 32'(gnt), 32'h0);
    check("mrst_count", 32'(count), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    check("mrst_done", 32'(done), 32'h0);
    req   = 4'b0000;
    rst_n = 1'b1;
    tick();
    check("mrst_after_done", 32'(done), 32'h0);
    check("mrst_after_gnt", 32'(gnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
